// File: rtl/mult_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state
// encoding and the operand magnitude helper used by the datapath.
package mult_seq_pkg;

  // Widest operand the design supports; abs_val works at this width.
  localparam int MAX_W = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Magnitude of an already sign/zero-extended operand. The most negative
  // value maps to 2^(W-1), which still fits unsigned in the operand width.
  function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] x,
                                               input logic             signed_mode);
    logic signed [MAX_W-1:0] x_s;
    x_s = x;
    if (signed_mode && x[MAX_W-1]) begin
      return -x_s;
    end
    return x;
  endfunction

endpackage

// File: rtl/mult_seq_ctrl_dp.sv
// Datapath of the sequential multiplier: magnitude conversion of the
// captured operands, shift-add accumulation and final sign correction.
// Optional build macro MULT_SEQ_EARLY_TERM_EN adds multiplier-zero flags
// used by the controller to stop iterating early.
module mult_seq_dp
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_step,
  input  logic               i_fix,
  input  logic               i_signed_mode,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
`ifdef MULT_SEQ_EARLY_TERM_EN
  output logic               o_mplier_zero,
  output logic               o_mplier_last,
`endif
  output logic [2*WIDTH-1:0] o_product
);

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_neg;
  logic [2*WIDTH-1:0] r_product;

  logic signed [WIDTH-1:0]     w_a_s;
  logic signed [WIDTH-1:0]     w_b_s;
  logic [MAX_W-1:0]            w_a_ext;
  logic [MAX_W-1:0]            w_b_ext;
  logic [MAX_W-1:0]            w_a_abs;
  logic [MAX_W-1:0]            w_b_abs;
  logic [WIDTH-1:0]            w_a_mag;
  logic [WIDTH-1:0]            w_b_mag;
  logic                        w_neg;
  logic signed [2*WIDTH-1:0]   w_acc_s;
  logic signed [2*WIDTH-1:0]   w_acc_neg_s;
  logic [2*WIDTH-1:0]          w_fixed;

  // Extend to the helper width honouring the operand mode, then take |x|.
  assign w_a_s   = i_a;
  assign w_b_s   = i_b;
  assign w_a_ext = i_signed_mode ? MAX_W'(w_a_s) : MAX_W'(i_a);
  assign w_b_ext = i_signed_mode ? MAX_W'(w_b_s) : MAX_W'(i_b);
  assign w_a_abs = abs_val(w_a_ext, i_signed_mode);
  assign w_b_abs = abs_val(w_b_ext, i_signed_mode);
  assign w_a_mag = w_a_abs[WIDTH-1:0];
  assign w_b_mag = w_b_abs[WIDTH-1:0];
  assign w_neg   = i_signed_mode & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);

  // Upper helper bits are zero for any legal operand; tie them off.
  generate
    if (WIDTH < MAX_W) begin : g_abs_unused
      logic w_unused_abs;
      assign w_unused_abs = ^{w_a_abs[MAX_W-1:WIDTH], w_b_abs[MAX_W-1:WIDTH]};
    end
  endgenerate

  // Two's-complement negation of the magnitude product for mixed signs.
  assign w_acc_s     = r_acc;
  assign w_acc_neg_s = -w_acc_s;
  assign w_fixed     = r_neg ? w_acc_neg_s : r_acc;

`ifdef MULT_SEQ_EARLY_TERM_EN
  assign o_mplier_zero = (r_mplier == '0);
  assign o_mplier_last = (r_mplier[WIDTH-1:1] == '0);
`endif

  assign o_product = r_product;

  // Operand load, one shift-add step per strobe, and product capture on fix.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_neg     <= 1'b0;
      r_product <= '0;
    end else begin
      if (i_load) begin
        r_neg    <= w_neg;
        r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
        r_mplier <= w_b_mag;
        r_acc    <= '0;
      end else if (i_step) begin
        if (r_mplier[0]) begin
          r_acc <= r_acc + r_mcand;
        end
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
      end
      if (i_fix) begin
        r_product <= w_fixed;
      end
    end
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential shift-add multiplier (ALU multi-cycle MUL unit): iteration
// controller FSM plus the mult_seq_dp datapath. start/busy/done handshake,
// unsigned or signed operands, abort, 2*WIDTH-bit product.
// Optional build macro MULT_SEQ_EARLY_TERM_EN: stop iterating as soon as the
// remaining multiplier bits are zero (same product, shorter latency).
module mult_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [CNT_W-1:0]   iter_cnt
);

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sm;

  logic             w_load;
  logic             w_step;
  logic             w_fix;
  logic             w_last_iter;
`ifdef MULT_SEQ_EARLY_TERM_EN
  logic             w_mplier_zero;
  logic             w_mplier_last;
`endif

  // Datapath strobes; abort suppresses any datapath update in that cycle.
  assign w_load = (r_state == LOAD) && !abort;
  assign w_fix  = (r_state == FIX)  && !abort;
`ifdef MULT_SEQ_EARLY_TERM_EN
  assign w_step      = (r_state == ITER) && !abort && !w_mplier_zero;
  assign w_last_iter = (r_cnt == CNT_W'(WIDTH - 1)) || w_mplier_last;
`else
  assign w_step      = (r_state == ITER) && !abort;
  assign w_last_iter = (r_cnt == CNT_W'(WIDTH - 1));
`endif

  mult_seq_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_load        (w_load),
    .i_step        (w_step),
    .i_fix         (w_fix),
    .i_signed_mode (r_sm),
    .i_a           (r_a),
    .i_b           (r_b),
`ifdef MULT_SEQ_EARLY_TERM_EN
    .o_mplier_zero (w_mplier_zero),
    .o_mplier_last (w_mplier_last),
`endif
    .o_product     (product)
  );

  assign busy     = r_busy;
  assign done     = r_done;
  assign iter_cnt = r_cnt;

  // Controller FSM with registered busy/done and iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sm    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_sm    <= signed_mode;
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt   <= '0;
            r_state <= ITER;
          end
        end
        ITER: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
`ifdef MULT_SEQ_EARLY_TERM_EN
            if (w_mplier_zero) begin
              r_state <= FIX;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
              if (w_last_iter) begin
                r_state <= FIX;
              end
            end
`else
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last_iter) begin
              r_state <= FIX;
            end
`endif
          end
        end
        FIX: begin
          r_busy <= 1'b0;
          if (abort) begin
            r_state <= IDLE;
          end else begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl (WIDTH=8): table-driven products
// through a scoreboard, plus hand-written abort, reset and start-while-busy
// sequences. Honours MULT_SEQ_EARLY_TERM_EN for latency/iteration expectations.
module tb_mult_seq_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
`ifdef MULT_SEQ_EARLY_TERM_EN
  localparam bit ET_BUILD = 1'b1;
`else
  localparam bit ET_BUILD = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               abort;
  logic               signed_mode;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;
  logic [CNT_W-1:0]   iter_cnt;

  mult_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .product     (product),
    .iter_cnt    (iter_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               sm;
    logic [2*WIDTH-1:0] prod;
  } vec_t;

  typedef struct {
    logic [2*WIDTH-1:0] prod;
    logic [CNT_W-1:0]   cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Iterations the DUT should execute: WIDTH normally, or the bit length of
  // |b| when early termination is built in.
  function automatic int exp_iters(input logic [WIDTH-1:0] bv, input logic sm);
    logic [WIDTH-1:0] m;
    int               n;
    m = (sm && bv[WIDTH-1]) ? -bv : bv;
    n = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (m[i]) n = i + 1;
    end
    return ET_BUILD ? n : WIDTH;
  endfunction

  // Edges from the start-sampling edge to the edge that raises done.
  function automatic int exp_edges(input int iters);
    return ((iters < 1) ? 1 : iters) + 2;
  endfunction

  // Scoreboard consumer: every done pops one expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: done=1 with no operation pending, expected done=0");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("product", 32'(product), 32'(e.prod));
        check("iter_cnt", 32'(iter_cnt), 32'(e.cnt));
      end
    end
  end

  // Full operation with latency, busy-length and single-pulse checks.
  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic sm, input logic [2*WIDTH-1:0] prod);
    int   iters;
    int   cyc;
    int   busy_n;
    bit   seen;
    exp_t e;
    iters = exp_iters(bv, sm);
    cyc = 0;
    busy_n = 0;
    seen = 1'b0;
    @(negedge clk);
    a = av; b = bv; signed_mode = sm; start = 1'b1;
    e.prod = prod;
    e.cnt  = CNT_W'(iters);
    sb_q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    busy_n += int'(busy);
    while (!seen && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) seen = 1'b1;
      else busy_n += int'(busy);
    end
    check("start_to_done_edges", 32'(cyc), 32'(exp_edges(iters)));
    check("busy_cycles", 32'(busy_n), 32'(exp_edges(iters)));
    check("busy_low_at_done", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("done_single_pulse", 32'(done), 32'd0);
  endtask

  vec_t vecs[12];
  logic [2*WIDTH-1:0] prev_prod;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; signed_mode = 1'b0; a = '0; b = '0;

    vecs[0]  = '{8'd13,  8'd11,  1'b0, 16'd143};
    vecs[1]  = '{8'hF9,  8'd6,   1'b1, 16'hFFD6};
    vecs[2]  = '{8'h80,  8'h80,  1'b1, 16'h4000};
    vecs[3]  = '{8'hFF,  8'hFF,  1'b0, 16'hFE01};
    vecs[4]  = '{8'h55,  8'h00,  1'b0, 16'h0000};
    vecs[5]  = '{8'd9,   8'd3,   1'b0, 16'd27};
    vecs[6]  = '{8'h80,  8'h7F,  1'b1, 16'hC080};
    vecs[7]  = '{8'hFF,  8'hFF,  1'b1, 16'h0001};
    vecs[8]  = '{8'h80,  8'h01,  1'b1, 16'hFF80};
    vecs[9]  = '{8'h80,  8'h80,  1'b0, 16'h4000};
    vecs[10] = '{8'h7F,  8'hFF,  1'b1, 16'hFF81};
    vecs[11] = '{8'h00,  8'h80,  1'b1, 16'h0000};

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    check("rst_iter_cnt", 32'(iter_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven products
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].prod);
    end

    // start pulsed during ITER is ignored; exactly one done
    begin
      exp_t e;
      int   cyc;
      @(negedge clk);
      a = 8'hFF; b = 8'hFF; signed_mode = 1'b0; start = 1'b1;
      e.prod = 16'hFE01;
      e.cnt  = CNT_W'(exp_iters(8'hFF, 1'b0));
      sb_q.push_back(e);
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1 a = 8'd1; b = 8'd1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cyc = 0;
      while (!done && cyc < 40) begin
        @(posedge clk);
        #1 cyc++;
      end
      check("busy_start_done_seen", 32'(done), 32'd1);
      repeat (15) @(posedge clk);
      #1;
      check("busy_start_idle", 32'(busy), 32'd0);
      check("busy_start_product_held", 32'(product), 32'hFE01);
    end

    // abort in the 4th ITER cycle
    prev_prod = 16'hFE01;
    @(negedge clk);
    a = 8'd5; b = 8'd5; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_product_held", 32'(product), 32'(prev_prod));
    check("abort_iter_cnt_held", 32'(iter_cnt), 32'd3);
    repeat (12) @(posedge clk);
    run_op(8'd5, 8'd5, 1'b0, 16'd25);

    // asynchronous reset between edges mid-ITER
    @(negedge clk);
    a = 8'd7; b = 8'd9; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_product", 32'(product), 32'd0);
    check("async_rst_iter_cnt", 32'(iter_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'd3, 8'd4, 1'b0, 16'd12);

    repeat (5) @(posedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
Parametrised sequential shift-add multiplier that combines the iteration controller and the datapath in one block. It is the successor to the fixed 3-bit-state multiply controller.
- Accepts WIDTH-bit operands through a start/busy/done handshake.
- Supports unsigned and signed (sign-magnitude-corrected) modes, plus abort.
- Produces a 2*WIDTH-bit product.
- Sits beside the ALU as its multi-cycle MUL unit.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
abort  in  1  cancel operation in progress
signed_mode  in  1  1 = two's-complement operands; sampled with start
a  in  WIDTH  multiplicand; sampled with start
b  in  WIDTH  multiplier; sampled with start
busy  out  1  high in LOAD, ITER, FIX
done  out  1  one-cycle pulse; product valid
product  out  2*WIDTH  result; held until the next done or reset
iter_cnt  out  CNT_W  ITER cycles executed in the last or current operation

Behaviour:
Reset (async, rst_n=0):
- state=IDLE, busy=0, done=0, product=0, iter_cnt=0, all internal registers 0.
- Reset mid-operation discards the operation; no done is issued.

States: IDLE, LOAD, ITER, FIX, DONE. Encoding is 3 bits, defined in the package.

IDLE:
- If start=1, capture a, b and signed_mode, then go to LOAD.
- Otherwise stay in IDLE.

LOAD:
- neg = signed_mode & (a[MSB]^b[MSB]).
- mcand = zero-extended |a| on 2*WIDTH bits.
- mplier = |b| on WIDTH bits.
- acc=0, iter_cnt=0, go to ITER.
- Magnitude of the most negative value is 2^(WIDTH-1); it fits unsigned in WIDTH bits.

ITER, per cycle:
- If mplier[0]=1, acc += mcand (modulo 2^(2*WIDTH); no overflow is possible).
- mcand <<= 1, mplier >>= 1, iter_cnt += 1.
- After WIDTH ITER cycles, go to FIX.

FIX:
- product <= neg ? -acc : acc (two's complement on 2*WIDTH bits).
- Go to DONE.

DONE:
- done=1 for this single cycle, busy=0.
- Go to IDLE unconditionally; start is ignored in DONE.

Latency:
- start is sampled at edge E.
- done is high during the cycle after edge E+WIDTH+2. Total WIDTH+3 cycles to done, WIDTH+4 until the next start is accepted.

Handshake rules:
- start while busy or in DONE is ignored; it is not queued.

abort:
- abort=1 in LOAD, ITER or FIX returns to IDLE at the next edge.
- product and done are unchanged; iter_cnt holds its value.
- abort in IDLE or DONE has no effect.
- Simultaneous start and abort in IDLE: start wins.

Optional Feature:
Macro MULT_SEQ_EARLY_TERM_EN.
- Defined: in ITER, if mplier==0 at the start of the cycle, no add and no iter_cnt increment occur, and the next state is FIX. Latency becomes (ITER cycles actually used)+3, minimum 4, which occurs when b=0.
- Undefined: always exactly WIDTH ITER cycles; the zero check logic is absent.
- The product value is identical in both builds.

Decomposition:
- Package mult_seq_pkg holds:
  - state typedef/localparams: IDLE=3'd0, LOAD=3'd1, ITER=3'd2, FIX=3'd3, DONE=3'd4;
  - a function abs_val(x, signed_mode).
- One natural sub-module, mult_seq_dp, holds the datapath: mcand/mplier/acc registers and the adder/negator.
  - It is driven by load, step and fix strobes from the FSM in mult_seq_ctrl.

Test Plan:
1. WIDTH=8 unsigned: a=8'd13, b=8'd11, start one cycle -> done exactly 11 cycles later, product=16'd143, iter_cnt=8, busy high 10 cycles.
2. WIDTH=8 signed: a=8'hF9 (-7), b=8'd6 -> product=16'hFFD6 (-42). Also a=b=8'h80 -> product=16'h4000.
3. Unsigned a=8'hFF, b=8'hFF -> product=16'hFE01. start pulsed again during ITER -> ignored, exactly one done.
4. abort asserted in the 4th ITER cycle after a=5, b=5 -> IDLE next edge, no done, product still holds the previous result. A new start then completes normally.
5. rst_n dropped asynchronously mid-ITER (between edges) -> busy, done and product go to 0 immediately. After release, the FSM is in IDLE and accepts start.
6. With MULT_SEQ_EARLY_TERM_EN, b=8'd3, a=8'd9 -> product=27, iter_cnt=2, done 5 cycles after start. Also b=0 -> product=0, done 4 cycles after start. Without the macro, both cases take 11 cycles with iter_cnt=8.
